serial_subtractor: RTL

- Bit-serial two's-complement subtractor computing diff = a - b, LSB first, one bit per clock through a single borrow flop.
- It is the inverse-direction companion to the team's ripple full-adder datapath: the same bit-cell idea, run as subtraction and time-multiplexed.
- Sits in the arithmetic primitives library and trades area for latency in low-rate filter datapaths.
- Operands enter, and results leave, over valid/ready handshakes.

---
 rtl/serial_subtractor.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one
// bit per clock through a single borrow flop, with valid/ready handshakes.
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   clear_i                   sync abort, drops any operation in flight
//   in_valid_i / in_ready_o   operand handshake (a_i minuend, b_i subtrahend)
//   out_valid_o / out_ready_i result handshake
//   diff_o                    a - b mod 2^WIDTH (0 while out_valid_o=0)
//   borrow_o                  1 iff a < b unsigned
//   overflow_o                signed overflow of a - b
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             overflow_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, d_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             a_msb_q, b_msb_q;

    logic accept;
    logic step;
    logic d_bit;
    logic br_next;

    assign accept = (state_q == IDLE) && in_valid_i && !clear_i;
    assign step   = (state_q == RUN) && !clear_i;

    assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid_i) state_d = RUN;
            RUN:  if (cnt_q == LAST) state_d = DONE;
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over both handshakes.
        if (clear_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (accept) begin
            a_q     <= a_i;
            b_q     <= b_i;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= a_i[WIDTH-1];
            b_msb_q <= b_i[WIDTH-1];
        end else if (step) begin
            a_q   <= {1'b0, a_q[WIDTH-1:1]};
            b_q   <= {1'b0, b_q[WIDTH-1:1]};
            // After WIDTH shifts the first bit computed sits in bit 0.
            d_q   <= {d_bit, d_q[WIDTH-1:1]};
            br_q  <= br_next;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);

    // Gate results so partial shift contents never leak out.
    assign diff_o     = out_valid_o ? d_q : '0;
    assign borrow_o   = out_valid_o & br_q;
    assign overflow_o = out_valid_o & (a_msb_q != b_msb_q)
                        & (d_q[WIDTH-1] != a_msb_q);

endmodule
